// File: rtl/arith_sched.sv
// arith_sched: round-robin scheduler that shares one registered 4-bit adder
// and one registered 4-bit multiplier between two requesters, returning
// tagged results on a single valid/ready response channel.
module arith_sched #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       req_valid,
    output logic [1:0]       req_ready,
    input  logic [1:0]       req_op,
    input  logic [7:0]       req_a,
    input  logic [7:0]       req_b,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic             rsp_op,
    output logic [7:0]       rsp_data,
    output logic [3:0]       add_in1,
    output logic [3:0]       add_in2,
    input  logic [4:0]       add_out,
    output logic [3:0]       mul_in1,
    output logic [3:0]       mul_in2,
    input  logic [7:0]       mul_out,
    output logic             busy,
    output logic [CNT_W-1:0] op_count
);

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        RESP
    } state_t;

    state_t            state_q, state_d;
    logic              opHold_q, opHold_d;
    logic              idHold_q, idHold_d;
    logic [3:0]        aHold_q, aHold_d;
    logic [3:0]        bHold_q, bHold_d;
    logic              lastGrant_q, lastGrant_d;
    logic [CNT_W-1:0]  count_q, count_d;

    logic              winner;
    logic              accept;
    logic              rspFire;

    // Round-robin pick: a lone requester wins, contention goes to the one not granted last
    always_comb begin
        winner = req_valid[1];
        if (req_valid == 2'b11) begin
            winner = ~lastGrant_q;
        end
    end

    // Next-state logic; an accept can happen from IDLE or in the same cycle a response is taken
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        rspFire = 1'b0;
        case (state_q)
            IDLE: begin
                if (|req_valid && !rst) begin
                    accept  = 1'b1;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                state_d = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    rspFire = 1'b1;
                    if (|req_valid && !rst) begin
                        accept  = 1'b1;
                        state_d = EXEC;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Holding-register, grant-history and counter next values
    always_comb begin
        opHold_d    = opHold_q;
        idHold_d    = idHold_q;
        aHold_d     = aHold_q;
        bHold_d     = bHold_q;
        lastGrant_d = lastGrant_q;
        count_d     = count_q;
        if (accept) begin
            opHold_d    = req_op[winner];
            idHold_d    = winner;
            aHold_d     = winner ? req_a[7:4] : req_a[3:0];
            bHold_d     = winner ? req_b[7:4] : req_b[3:0];
            lastGrant_d = winner;
        end
        if (rspFire) begin
            count_d = count_q + 1'b1;
        end
    end

    // State and holding registers; reset discards any in-flight operation
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            opHold_q    <= 1'b0;
            idHold_q    <= 1'b0;
            aHold_q     <= 4'd0;
            bHold_q     <= 4'd0;
            lastGrant_q <= 1'b1;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            opHold_q    <= opHold_d;
            idHold_q    <= idHold_d;
            aHold_q     <= aHold_d;
            bHold_q     <= bHold_d;
            lastGrant_q <= lastGrant_d;
            count_q     <= count_d;
        end
    end

    // Drive only the selected unit while an op is in flight; the other sees zeros
    always_comb begin
        add_in1 = 4'd0;
        add_in2 = 4'd0;
        mul_in1 = 4'd0;
        mul_in2 = 4'd0;
        if (state_q != IDLE) begin
            if (opHold_q) begin
                mul_in1 = aHold_q;
                mul_in2 = bHold_q;
            end else begin
                add_in1 = aHold_q;
                add_in2 = bHold_q;
            end
        end
    end

    // Response channel and status outputs
    always_comb begin
        req_ready = 2'b00;
        if (accept) begin
            req_ready = winner ? 2'b10 : 2'b01;
        end
        rsp_valid = (state_q == RESP);
        rsp_id    = 1'b0;
        rsp_op    = 1'b0;
        rsp_data  = 8'd0;
        if (state_q == RESP) begin
            rsp_id   = idHold_q;
            rsp_op   = opHold_q;
            rsp_data = opHold_q ? mul_out : {3'b000, add_out};
        end
        busy     = (state_q != IDLE);
        op_count = count_q;
    end

endmodule

// File: tb/tb_arith_sched.sv
// tb_arith_sched: directed and random stimulus against a transaction-level
// reference model of the scheduler, with registered adder/multiplier models.
module tb_arith_sched;

    localparam int CNT_W = 4;

    logic             clk;
    logic             rst;
    logic [1:0]       req_valid;
    logic [1:0]       req_ready;
    logic [1:0]       req_op;
    logic [7:0]       req_a;
    logic [7:0]       req_b;
    logic             rsp_valid;
    logic             rsp_ready;
    logic             rsp_id;
    logic             rsp_op;
    logic [7:0]       rsp_data;
    logic [3:0]       add_in1, add_in2, mul_in1, mul_in2;
    logic [4:0]       add_out;
    logic [7:0]       mul_out;
    logic             busy;
    logic [CNT_W-1:0] op_count;

    int checks = 0;
    int errors = 0;

    // Requester-side pending operations and consumer readiness
    logic [1:0] pendV;
    logic [1:0] pendOp;
    logic [3:0] pendA [2];
    logic [3:0] pendB [2];
    logic       rspRdy;

    // Reference model: one in-flight op and how many cycles since it was accepted
    bit   inflight;
    int   age;
    bit   curId, curOp;
    int   curA, curB;
    bit   lastGrant;
    int   count;
    logic [7:0] lastRspData;

    arith_sched #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_a(req_a), .req_b(req_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_op(rsp_op), .rsp_data(rsp_data),
        .add_in1(add_in1), .add_in2(add_in2), .add_out(add_out),
        .mul_in1(mul_in1), .mul_in2(mul_in2), .mul_out(mul_out),
        .busy(busy), .op_count(op_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Registered adder and multiplier sharing the scheduler's clock and reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            add_out <= 5'd0;
            mul_out <= 8'd0;
        end else begin
            add_out <= {1'b0, add_in1} + {1'b0, add_in2};
            mul_out <= {4'd0, mul_in1} * {4'd0, mul_in2};
        end
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic setOp(input int i, input bit op, input int a, input int b);
        pendV[i]  = 1'b1;
        pendOp[i] = op;
        pendA[i]  = 4'(a);
        pendB[i]  = 4'(b);
    endtask

    task automatic refill(input int i);
        setOp(i, 1'($urandom_range(0, 1)), int'($urandom_range(0, 15)), int'($urandom_range(0, 15)));
    endtask

    task automatic driveInputs();
        req_valid = pendV;
        req_op    = pendOp;
        req_a     = {pendA[1], pendA[0]};
        req_b     = {pendB[1], pendB[0]};
        rsp_ready = rspRdy;
    endtask

    task automatic modelReset();
        inflight  = 1'b0;
        age       = 0;
        lastGrant = 1'b1;
        count     = 0;
    endtask

    task automatic checkAllZero(input string tag);
        check({tag, " req_ready"}, 16'(req_ready), 16'd0);
        check({tag, " rsp_valid"}, 16'(rsp_valid), 16'd0);
        check({tag, " rsp_data"}, 16'(rsp_data), 16'd0);
        check({tag, " rsp_id"}, 16'(rsp_id), 16'd0);
        check({tag, " busy"}, 16'(busy), 16'd0);
        check({tag, " op_count"}, 16'(op_count), 16'd0);
        check({tag, " add_in"}, {8'd0, add_in1, add_in2}, 16'd0);
        check({tag, " mul_in"}, {8'd0, mul_in1, mul_in2}, 16'd0);
    endtask

    task automatic doReset();
        pendV  = 2'b00;
        rspRdy = 1'b0;
        driveInputs();
        rst = 1'b1;
        #1;
        checkAllZero("reset");
        modelReset();
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    // One clock cycle: drive, compare against the model, advance the model across the edge
    task automatic applyStimulus();
        bit         expRspValid, fire, canAcc, win;
        logic [1:0] expReady;
        int         expData;
        driveInputs();
        #1;
        expRspValid = inflight && (age >= 2);
        fire        = expRspValid && rspRdy;
        canAcc      = !inflight || fire;
        win         = (pendV == 2'b11) ? !lastGrant : pendV[1];
        expReady    = (canAcc && (pendV != 2'b00)) ? (win ? 2'b10 : 2'b01) : 2'b00;
        expData     = curOp ? (curA * curB) : (curA + curB);
        checkOutput(expRspValid, expReady, expData);
        if (fire) begin
            count++;
            inflight = 1'b0;
        end
        if (expReady != 2'b00) begin
            inflight    = 1'b1;
            age         = 1;
            curId       = win;
            curOp       = pendOp[win];
            curA        = int'(pendA[win]);
            curB        = int'(pendB[win]);
            pendV[win]  = 1'b0;
            lastGrant   = win;
        end else if (inflight) begin
            age++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input bit expRspValid, input logic [1:0] expReady, input int expData);
        check("req_ready", 16'(req_ready), 16'(expReady));
        check("rsp_valid", 16'(rsp_valid), 16'(expRspValid));
        check("busy", 16'(busy), 16'(inflight));
        check("op_count", 16'(op_count), 16'(count % (1 << CNT_W)));
        if (expRspValid) begin
            lastRspData = rsp_data;
            check("rsp_data", 16'(rsp_data), 16'(expData));
            check("rsp_id", 16'(rsp_id), 16'(curId));
            check("rsp_op", 16'(rsp_op), 16'(curOp));
        end
        if (inflight) begin
            check("add_in", {8'd0, add_in1, add_in2}, curOp ? 16'd0 : 16'((curA << 4) | curB));
            check("mul_in", {8'd0, mul_in1, mul_in2}, curOp ? 16'((curA << 4) | curB) : 16'd0);
        end
    endtask

    task automatic drain();
        int n = 0;
        rspRdy = 1'b1;
        while ((inflight || pendV != 2'b00) && n < 20) begin
            applyStimulus();
            n++;
        end
        check("drain bound", 16'(inflight || pendV != 2'b00), 16'd0);
    endtask

    initial begin
        rst       = 1'b1;
        pendV     = 2'b00;
        pendOp    = 2'b00;
        pendA[0]  = 4'd0; pendA[1] = 4'd0;
        pendB[0]  = 4'd0; pendB[1] = 4'd0;
        rspRdy    = 1'b0;
        curId     = 1'b0; curOp = 1'b0; curA = 0; curB = 0;
        lastRspData = 8'd0;
        driveInputs();
        modelReset();
        doReset();

        // Requester 0: add 9+8
        $display("[TB] add 9+8 from requester 0");
        setOp(0, 1'b0, 9, 8);
        rspRdy = 1'b1;
        repeat (3) applyStimulus();
        check("add 9+8 data", 16'(lastRspData), 16'h11);
        applyStimulus();
        check("count after first", 16'(op_count), 16'd1);

        // Requester 1: mul 15*15
        $display("[TB] mul 15*15 from requester 1");
        setOp(1, 1'b1, 15, 15);
        repeat (3) applyStimulus();
        check("mul 15*15 data", 16'(lastRspData), 16'hE1);
        applyStimulus();

        // Continuous contention: grants alternate, one response every 2 cycles
        $display("[TB] continuous contention");
        doReset();
        rspRdy = 1'b1;
        for (int c = 0; c < 17; c++) begin
            if (!pendV[0]) refill(0);
            if (!pendV[1]) refill(1);
            applyStimulus();
        end
        check("count after 8", 16'(op_count), 16'd8);
        drain();

        // Consumer stall holding a 15+15 result
        $display("[TB] consumer stall");
        setOp(0, 1'b0, 15, 15);
        rspRdy = 1'b1;
        applyStimulus();
        rspRdy = 1'b0;
        applyStimulus();
        refill(0);
        refill(1);
        repeat (5) applyStimulus();
        check("stall data", 16'(lastRspData), 16'h1E);
        check("stall valid", 16'(rsp_valid), 16'd1);
        rspRdy = 1'b1;
        applyStimulus();
        drain();

        // Reset during EXEC of mul 7*7
        $display("[TB] reset mid-operation");
        setOp(0, 1'b1, 7, 7);
        rspRdy = 1'b1;
        applyStimulus();
        pendV = 2'b00;
        driveInputs();
        rst = 1'b1;
        #1;
        checkAllZero("mid reset");
        modelReset();
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        setOp(0, 1'b0, 1, 2);
        repeat (3) applyStimulus();
        check("post reset add", 16'(lastRspData), 16'h03);
        drain();

        // Random traffic with random consumer back-pressure
        $display("[TB] random traffic");
        for (int c = 0; c < 300; c++) begin
            if (!pendV[0] && $urandom_range(0, 2) != 0) refill(0);
            if (!pendV[1] && $urandom_range(0, 2) != 0) refill(1);
            rspRdy = ($urandom_range(0, 3) != 0);
            applyStimulus();
        end
        drain();

        // Counter wrap: 17 completions on a 4-bit counter
        $display("[TB] counter wrap");
        doReset();
        rspRdy = 1'b1;
        for (int c = 0; c < 35; c++) begin
            if (!pendV[0]) refill(0);
            applyStimulus();
        end
        check("count wrap", 16'(op_count), 16'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/arith_sched.md
# arith_sched

Round-robin scheduler that shares the registered 4-bit adder and 4-bit multiplier between two requesters. Each requester submits an operation (add or mul) with two 4-bit operands over a valid/ready handshake. The block sequences the selected unit, then returns the result on a single tagged response channel with its own valid/ready handshake. It sits between the requesting masters and the adder/mul instances, which share its clk and rst.

## Interface
- CNT_W, 16, width of the completed-operation counter
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high; also wired to the adder/mul instances
- req_valid  in  2  bit i: requester i presents an operation
- req_ready  out  2  bit i: requester i's operation is accepted this cycle
- req_op  in  2  bit i: requester i opcode, 0 = add, 1 = mul
- req_a  in  8  operand A; [3:0] requester 0, [7:4] requester 1
- req_b  in  8  operand B; same packing as req_a
- rsp_valid  out  1  response present
- rsp_ready  in  1  response consumer accepts
- rsp_id  out  1  requester that owns the response
- rsp_op  out  1  opcode of the response
- rsp_data  out  8  result; add result zero-extended from 5 bits
- add_in1, add_in2  out  4 each  adder operand drive
- add_out  in  5  registered adder result
- mul_in1, mul_in2  out  4 each  multiplier operand drive
- mul_out  in  8  registered multiplier result
- busy  out  1  high whenever state is not IDLE
- op_count  out  CNT_W  count of completed response handshakes; wraps modulo 2^CNT_W

## Operation
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - If any req_valid bit is set, the arbiter picks a winner and asserts req_ready[winner] combinationally in the same cycle.
  - On that clock edge the block captures the winner's op, A, B and id into holding registers and moves to EXEC.
  - With no req_valid, it stays in IDLE.
- Arbitration:
  - If only one requester is valid, it wins.
  - If both are valid, the winner is the requester that is not last_grant.
  - last_grant updates on each acceptance and resets to 1, so requester 0 wins the first contention.
- Unit drive:
  - The holding registers drive the selected unit's inputs. The unselected unit's inputs are driven to 0.
  - Operands stay stable from EXEC until the response handshake completes.
- EXEC lasts one cycle; the unit registers its result at the end of EXEC. Next state is RESP.
- RESP:
  - rsp_valid = 1.
  - rsp_data = {3'b0, add_out} when op = 0, or mul_out when op = 1.
  - rsp_id and rsp_op come from the holding registers.
  - rsp_data is stable while stalled, because the operands are held.
- Leaving RESP on rsp_valid && rsp_ready:
  - op_count increments.
  - If any req_valid bit is set in that same cycle, req_ready[winner] asserts (a combinational path from rsp_ready to req_ready is allowed), the new operation is captured, and the next state is EXEC.
  - Otherwise the next state is IDLE.
- req_ready is 0 in EXEC, and in RESP when rsp_ready = 0.
- At most one req_ready bit is high in any cycle.
- Arithmetic: add 15+15 = 30 (5'b11110); mul 15*15 = 225 (8'hE1). No overflow is possible at these widths.

## Timing
- Reset values (async assert):
  - State IDLE; rsp_valid, rsp_id, rsp_op, rsp_data and req_ready = 0.
  - All unit operand outputs = 0; holding registers = 0.
  - op_count = 0, busy = 0, last_grant = 1.
  - The units' own outputs also clear, so rsp_data = 0 combinationally.
- Reset mid-operation (EXEC or RESP) discards the in-flight op. No response is issued for it, and the next accept after deassertion starts clean.
- Latency: accept at edge T; EXEC during cycle T+1; rsp_valid high in cycle T+2.
- Throughput: one op per 2 cycles with rsp_ready tied high and a continuous request stream; one per 3 cycles through IDLE otherwise.
- Requester obligation: hold req_valid, req_op and operands stable until req_ready. The block does not sample them except in the accept cycle.
- Consumer stall: rsp_valid, rsp_id, rsp_op and rsp_data hold unchanged for any number of cycles until rsp_ready.

## Test plan
- Reset, then requester 0 issues add 9+8 with rsp_ready = 1 → req_ready[0] high in cycle 0; rsp_valid in cycle 2 with rsp_data = 0x11, rsp_id = 0, rsp_op = 0; op_count = 1.
- Requester 1 issues mul 15*15 → rsp_data = 0xE1, rsp_id = 1; add_in1/add_in2 are 0 throughout.
- Both requesters valid continuously with mixed ops and rsp_ready = 1 → grants alternate 0,1,0,1; a response every 2 cycles; op_count = 8 after 8 responses.
- rsp_ready held low for 5 cycles in RESP → rsp_valid and rsp_data = 0x1E (15+15) stable; req_ready stays 0 despite pending requests; accept occurs in the handshake cycle.
- Assert rst during EXEC of mul 7*7 → all outputs 0 immediately; no response for that op; a post-reset add 1+2 returns 0x03.
- CNT_W = 4, 17 completed ops → op_count = 1 (wrap).
